// File: rtl/pipeline_advance_ctrl_if.sv
// Handshake bundle between the memory/hazard units and the pipeline advance controller.
// The controller connects through the slave modport; the stimulus side uses master.
interface pipeline_advance_ctrl_if;
  logic imem_resp;
  logic dmem_req;
  logic dmem_resp;
  logic load_use;
  logic br_taken;
  logic load_pc;
  logic load_if_id;
  logic load_id_ex;
  logic load_ex_mem;
  logic load_mem_wb;
  logic flush_if_id;
  logic flush_id_ex;
  logic imem_capture;
  logic dmem_capture;

  modport master (
    output imem_resp, dmem_req, dmem_resp, load_use, br_taken,
    input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    input  flush_if_id, flush_id_ex, imem_capture, dmem_capture
  );

  modport slave (
    input  imem_resp, dmem_req, dmem_resp, load_use, br_taken,
    output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    output flush_if_id, flush_id_ex, imem_capture, dmem_capture
  );
endinterface

// File: rtl/pipeline_advance_ctrl.sv
// Pipeline advance/stall/bubble/flush controller for the 5-stage rv32i pipe.
// Remembers early I/D responses across memory stalls and keeps saturating perf counters.
module pipeline_advance_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_advance_ctrl_if.slave pif,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] bubble_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] IHELD = 2'd1;
  localparam logic [1:0] DHELD = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic       i_done;
  logic       d_done;
  logic       i_ok;
  logic       d_ok;
  logic       adv;
  logic [2:0] cnt_inc;
  logic [3*CNT_WIDTH-1:0] cnt_flat;

  assign i_done = (state_reg == IHELD);
  assign d_done = (state_reg == DHELD);
  assign i_ok   = i_done | pif.imem_resp;
  assign d_ok   = !pif.dmem_req | d_done | pif.dmem_resp;
  assign adv    = i_ok & d_ok & !rst;

  always_comb begin
    pif.load_pc      = 1'b0;
    pif.load_if_id   = 1'b0;
    pif.load_id_ex   = 1'b0;
    pif.load_ex_mem  = 1'b0;
    pif.load_mem_wb  = 1'b0;
    pif.flush_if_id  = 1'b0;
    pif.flush_id_ex  = 1'b0;
    pif.imem_capture = 1'b0;
    pif.dmem_capture = 1'b0;
    if (adv) begin
      pif.load_id_ex  = 1'b1;
      pif.load_ex_mem = 1'b1;
      pif.load_mem_wb = 1'b1;
      if (pif.br_taken) begin
        pif.load_pc     = 1'b1;
        pif.load_if_id  = 1'b1;
        pif.flush_if_id = 1'b1;
        pif.flush_id_ex = 1'b1;
      end else if (pif.load_use) begin
        // Hold PC and IF/ID so the dependent instruction re-enters ID next cycle.
        pif.flush_id_ex = 1'b1;
      end else begin
        pif.load_pc    = 1'b1;
        pif.load_if_id = 1'b1;
      end
    end else if (!rst) begin
      pif.imem_capture = pif.imem_resp & !i_done;
      pif.dmem_capture = pif.dmem_resp & pif.dmem_req & !d_done;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (adv) begin
      state_next = RUN;
    end else if (!i_done && !d_done) begin
      if (pif.imem_resp && !d_ok) begin
        state_next = IHELD;
      end else if (pif.dmem_resp && pif.dmem_req && !pif.imem_resp) begin
        state_next = DHELD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  assign cnt_inc[0] = !adv & !rst;
  assign cnt_inc[1] = adv & !pif.br_taken & pif.load_use;
  assign cnt_inc[2] = adv & pif.br_taken;

  // Counter slots: 0 = stall, 1 = bubble, 2 = flush.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != CNT_MAX)) begin
          cnt_reg <= cnt_reg + CNT_ONE;
        end
      end
      assign cnt_flat[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
    end
  endgenerate

  assign stall_cnt  = cnt_flat[0*CNT_WIDTH +: CNT_WIDTH];
  assign bubble_cnt = cnt_flat[1*CNT_WIDTH +: CNT_WIDTH];
  assign flush_cnt  = cnt_flat[2*CNT_WIDTH +: CNT_WIDTH];

endmodule
